// File: rtl/ecc_pkg.sv
// Shared secp256k1 constants and the point_validate state encoding.
package ecc_pkg;
  localparam int unsigned ECC_W      = 256;
  localparam int unsigned MUL_CYCLES = 257;

  localparam logic [ECC_W-1:0] ECC_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [ECC_W-1:0] ECC_B = 256'd7;

  typedef enum logic [2:0] {
    IDLE,
    RANGE,
    MUL_YY,
    MUL_XX,
    MUL_XXX,
    CMP,
    DONE
  } pv_state_t;
endpackage

// File: rtl/point_validate_if.sv
// Candidate-point request / verdict bus between the sender and point_validate.
interface point_validate_if;
  import ecc_pkg::*;

  logic             in_valid;
  logic [ECC_W-1:0] Px;
  logic [ECC_W-1:0] Py;
  logic [ECC_W-1:0] k;
  logic             busy;
  logic             out_valid;
  logic             on_curve;
  logic [ECC_W-1:0] Qx;
  logic [ECC_W-1:0] Qy;
  logic [ECC_W-1:0] k_o;

  modport master (
    output in_valid, Px, Py, k,
    input  busy, out_valid, on_curve, Qx, Qy, k_o
  );

  modport slave (
    input  in_valid, Px, Py, k,
    output busy, out_valid, on_curve, Qx, Qy, k_o
  );
endinterface

// File: rtl/mod_mul_serial.sv
// Bit-serial MSB-first modular multiplier: one load edge on start, then 256
// double-and-add iterations; done pulses with result = a*b mod modulus.
module mod_mul_serial
  import ecc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ECC_W-1:0] a,
  input  logic [ECC_W-1:0] b,
  input  logic [ECC_W-1:0] modulus,
  output logic             done,
  output logic [ECC_W-1:0] result
);
  localparam int unsigned DW = ECC_W + 2;
  localparam int unsigned CW = $clog2(MUL_CYCLES);

  logic [ECC_W-1:0] a_q, b_q, m_q, acc_q;
  logic [CW-1:0]    cnt_q;
  logic [DW-1:0]    m_ext_c, sum_c, red1_c, red2_c;

  // 2*acc + a_i*b stays below 3*modulus, so two subtractions restore acc < modulus
  always_comb begin
    m_ext_c = {2'b00, m_q};
    sum_c   = {1'b0, acc_q, 1'b0} + (a_q[ECC_W-1] ? {2'b00, b_q} : '0);
    red1_c  = (sum_c >= m_ext_c) ? sum_c - m_ext_c : sum_c;
    red2_c  = (red1_c >= m_ext_c) ? red1_c - m_ext_c : red1_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      done  <= 1'b0;
    end else if (start) begin
      a_q   <= a;
      b_q   <= b;
      m_q   <= modulus;
      acc_q <= '0;
      cnt_q <= CW'(MUL_CYCLES - 1);
      done  <= 1'b0;
    end else if (cnt_q != '0) begin
      acc_q <= ECC_W'(red2_c);
      a_q   <= {a_q[ECC_W-2:0], 1'b0};
      cnt_q <= cnt_q - CW'(1);
      done  <= (cnt_q == CW'(1));
    end else begin
      done  <= 1'b0;
    end
  end

  assign result = acc_q;
endmodule

// File: rtl/point_validate.sv
// On-curve check of a candidate point (y^2 == x^3 + 7 mod P) ahead of dotProduct.
// POINT_VALIDATE_RANGE_CHECK_EN adds the RANGE state rejecting coordinates >= P.
module point_validate
  import ecc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  point_validate_if.slave bus
);
  pv_state_t        state_q, state_c;
  logic [ECC_W-1:0] qx_q, qy_q, k_q, y2_q;
  logic             verdict_q, out_valid_q, on_curve_q, busy_q;
  logic             capture_c, mul_start_c, mul_done;
  logic [ECC_W-1:0] mul_a_c, mul_b_c, mul_res, y_src_c, rhs_c;
  logic [ECC_W:0]   rhs_sum_c;

`ifdef POINT_VALIDATE_RANGE_CHECK_EN
  logic out_of_range_c;
  assign out_of_range_c = (qx_q >= ECC_P) || (qy_q >= ECC_P);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_c;
  end

  // Next state; the multiplier is started on the edge that enters each MUL state
  always_comb begin
    state_c   = state_q;
    capture_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          capture_c = 1'b1;
`ifdef POINT_VALIDATE_RANGE_CHECK_EN
          state_c   = RANGE;
`else
          state_c   = MUL_YY;
`endif
        end
      end
`ifdef POINT_VALIDATE_RANGE_CHECK_EN
      RANGE:   state_c = out_of_range_c ? DONE : MUL_YY;
`endif
      MUL_YY:  if (mul_done) state_c = MUL_XX;
      MUL_XX:  if (mul_done) state_c = MUL_XXX;
      MUL_XXX: if (mul_done) state_c = CMP;
      CMP:     state_c = DONE;
      DONE:    state_c = IDLE;
      default: state_c = IDLE;
    endcase
    mul_start_c = (state_c != state_q) && (state_c inside {MUL_YY, MUL_XX, MUL_XXX});
  end

  // Qy is not yet captured when MUL_YY is entered straight from IDLE
  assign y_src_c = (state_q == IDLE) ? bus.Py : qy_q;

  always_comb begin
    mul_a_c = y_src_c;
    mul_b_c = y_src_c;
    if (state_c == MUL_XX) begin
      mul_a_c = qx_q;
      mul_b_c = qx_q;
    end else if (state_c == MUL_XXX) begin
      mul_a_c = mul_res;
      mul_b_c = qx_q;
    end
  end

  mod_mul_serial u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start_c),
    .a       (mul_a_c),
    .b       (mul_b_c),
    .modulus (ECC_P),
    .done    (mul_done),
    .result  (mul_res)
  );

  // x3 + B reduced once; x3 < P and B small keep the sum below 2P
  always_comb begin
    rhs_sum_c = {1'b0, mul_res} + {1'b0, ECC_B};
    rhs_c     = ECC_W'((rhs_sum_c >= {1'b0, ECC_P}) ? rhs_sum_c - {1'b0, ECC_P} : rhs_sum_c);
  end

  // Capture registers, y^2 holding, verdict and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qx_q        <= '0;
      qy_q        <= '0;
      k_q         <= '0;
      y2_q        <= '0;
      verdict_q   <= 1'b0;
      out_valid_q <= 1'b0;
      on_curve_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (capture_c) begin
        qx_q      <= bus.Px;
        qy_q      <= bus.Py;
        k_q       <= bus.k;
        verdict_q <= 1'b0;
      end
      if ((state_q == MUL_YY) && mul_done) y2_q <= mul_res;
      if (state_q == CMP) verdict_q <= (y2_q == rhs_c);
      out_valid_q <= (state_q == DONE);
      on_curve_q  <= (state_q == DONE) && verdict_q;
      busy_q      <= (state_q != IDLE);
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.on_curve  = on_curve_q;
  assign bus.Qx        = qx_q;
  assign bus.Qy        = qy_q;
  assign bus.k_o       = k_q;
endmodule

// File: tb/tb_point_validate.sv
// Directed bench for point_validate with a scoreboard of expected verdicts,
// latencies and captured values, checked whenever out_valid pulses.
module tb_point_validate;
  import ecc_pkg::*;

  localparam logic [255:0] GX =
    256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam logic [255:0] GY =
    256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
`ifdef POINT_VALIDATE_RANGE_CHECK_EN
  localparam int unsigned LAT     = 774;
  localparam int unsigned LAT_OOR = 2;
  localparam logic        CHK_OOR = 1'b1;
`else
  localparam int unsigned LAT     = 773;
  localparam int unsigned LAT_OOR = 773;
  localparam logic        CHK_OOR = 1'b0;
`endif

  typedef struct {
    int unsigned  cap;
    int unsigned  lat;
    logic         oc;
    logic         chk_oc;
    logic [255:0] qx;
    logic [255:0] qy;
    logic [255:0] k;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  point_validate_if bus();

  point_validate dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every out_valid must match the oldest outstanding request
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 256'(bus.out_valid), 256'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("latency", 256'(cyc - e.cap), 256'(e.lat));
        if (e.chk_oc) check("on_curve", 256'(bus.on_curve), 256'(e.oc));
        check("Qx", bus.Qx, e.qx);
        check("Qy", bus.Qy, e.qy);
        check("k_o", bus.k_o, e.k);
        check("busy_at_out_valid", 256'(bus.busy), 256'd1);
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the capture edge
  task automatic send(input logic [255:0] px, input logic [255:0] py, input logic [255:0] kk,
                      input logic oc, input logic chk, input int unsigned lat);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.Px = px;
    bus.Py = py;
    bus.k  = kk;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    e.cap = cyc; e.lat = lat; e.oc = oc; e.chk_oc = chk;
    e.qx = px; e.qy = py; e.k = kk;
    sb.push_back(e);
    check("busy_capture_cycle", 256'(bus.busy), 256'd0);
    check("Qx_captured", bus.Qx, px);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 256'(sb.size()), 256'd0);
    @(negedge clk);
    check("busy_after_done", 256'(bus.busy), 256'd0);
  endtask

  task automatic wait_ov(input string tag, input int budget);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 256'(bus.out_valid), 256'd1);
  endtask

  initial begin
    int unsigned cap1;
    bus.in_valid = 1'b0;
    bus.Px = '0;
    bus.Py = '0;
    bus.k  = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 256'(bus.out_valid), 256'd0);
    check("rst_on_curve", 256'(bus.on_curve), 256'd0);
    check("rst_busy", 256'(bus.busy), 256'd0);
    check("rst_Qx", bus.Qx, 256'd0);
    check("rst_Qy", bus.Qy, 256'd0);
    check("rst_k_o", bus.k_o, 256'd0);
    rst = 1'b0;
    @(negedge clk);

    // Generator point
    send(GX, GY, 256'd1, 1'b1, 1'b1, LAT);
    @(negedge clk);
    check("busy_cycle1", 256'(bus.busy), 256'd1);
    wait_drain("g_result", LAT + 10);

    // Off-curve neighbour of G
    send(GX, GY + 256'd1, 256'd5, 1'b0, 1'b1, LAT);
    wait_drain("gy1_result", LAT + 10);

    // x equal to P
    send(ECC_P, GY, 256'd7, 1'b0, CHK_OOR, LAT_OOR);
    wait_drain("oor_result", LAT + 10);

    // (0,0) with a pulse at cycle 100 that must be ignored
    send(256'd0, 256'd0, 256'd3, 1'b0, 1'b1, LAT);
    repeat (99) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.Px = GX;
    bus.Py = GY;
    bus.k  = 256'd9;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("ignored_pulse_Qx", bus.Qx, 256'd0);
    wait_drain("zero_result", LAT + 10);

    // Reset during MUL_XX aborts the point
    send(GX, GY, 256'd1, 1'b1, 1'b1, LAT);
    repeat (300) @(negedge clk);
    rst = 1'b1;
    #1;
    sb.delete();
    check("abort_out_valid", 256'(bus.out_valid), 256'd0);
    check("abort_on_curve", 256'(bus.on_curve), 256'd0);
    check("abort_busy", 256'(bus.busy), 256'd0);
    check("abort_Qx", bus.Qx, 256'd0);
    check("abort_Qy", bus.Qy, 256'd0);
    check("abort_k_o", bus.k_o, 256'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(GX, GY, 256'd1, 1'b1, 1'b1, LAT);
    wait_drain("after_reset_result", LAT + 10);

    // Back-to-back: second request on the cycle after out_valid
    send(GX, GY, 256'd1, 1'b1, 1'b1, LAT);
    cap1 = cyc;
    wait_ov("b2b_first", LAT + 10);
    send(GX, GY, 256'd2, 1'b1, 1'b1, LAT);
    check("b2b_spacing", 256'(cyc - cap1), 256'(LAT + 1));
    wait_drain("b2b_second", LAT + 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/point_validate.md
# point_validate

Upstream stage of `dotProduct`: accepts a candidate base point (Px, Py) and scalar k, and checks that the point lies on y² = x³ + B mod P (A = 0, secp256k1 default). It then forwards the point and scalar with an on-curve verdict. The top level drives `dotProduct.in_valid` with `out_valid & on_curve`, so invalid points never enter scalar multiplication. Verification uses a bit-serial modular multiplier, so the area is small and the latency is fixed.

## Interface
- `P`, 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F, field prime.
- `B`, 256'd7, curve constant b.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  one-cycle pulse qualifying Px/Py/k.
- `Px`, `Py`  in  256  candidate point.
- `k`  in  256  scalar, passed through untouched.
- `busy`  out  1  high from capture until the out_valid cycle inclusive.
- `out_valid`  out  1  one-cycle result pulse.
- `on_curve`  out  1  verdict, meaningful only when out_valid=1.
- `Qx`, `Qy`, `k_o`  out  256  captured Px/Py/k, held stable from capture until the next capture.

## Operation
- States: IDLE, RANGE, MUL_YY, MUL_XX, MUL_XXX, CMP, DONE.
- IDLE:
  - `in_valid=1` captures Px/Py/k into Qx/Qy/k_o and moves to RANGE.
  - `in_valid=0` holds IDLE.
- `in_valid` is ignored in every state except IDLE. No queueing; dropped pulses are the sender's fault.
- RANGE: if Qx ≥ P or Qy ≥ P, set verdict=0 and go to DONE. Otherwise go to MUL_YY.
- MUL_YY: y2 = Qy·Qy mod P.
- MUL_XX: x2 = Qx·Qx mod P.
- MUL_XXX: x3 = x2·Qx mod P.
- Each MUL state takes 257 cycles: 1 load cycle, then 256 iterations.
  - Iterations run MSB-first over multiplier bit i: acc ← 2·acc + a_i·b, with two conditional subtractions of P per cycle. acc is always < P.
  - The intermediate datapath is 258 bits wide.
- CMP: rhs = x3 + B, minus P if the sum is ≥ P. Set verdict = (y2 == rhs). Go to DONE.
- DONE: drive out_valid=1 and on_curve=verdict for one cycle, then return to IDLE.
- Point at infinity is not representable. (0,0) is evaluated arithmetically and gives 0 ≠ B, so it is invalid.

## Timing
- Capture edge = cycle 0.
- Valid-range point: out_valid=1 in cycle 774 (1 RANGE + 3×257 MUL + 1 CMP + 1 DONE).
- Out-of-range point: out_valid=1 in cycle 2.
- busy rises in cycle 1 and falls after the out_valid cycle.
- A new in_valid is accepted in the first cycle after out_valid, so back-to-back throughput is 775 cycles per point.
- Reset values: out_valid=0, on_curve=0, busy=0, Qx=Qy=k_o=0, state=IDLE, all accumulators 0.
- Reset asserted mid-operation aborts immediately. No out_valid is produced for the aborted point.
- in_valid coincident with reset deassertion is ignored.

## Configuration
- `POINT_VALIDATE_RANGE_CHECK_EN` defined:
  - The RANGE state exists.
  - Valid-range latency is 774; out-of-range latency is 2.
- Macro undefined:
  - The RANGE state is removed and IDLE goes straight to MUL_YY, so every latency is 773.
  - Inputs are assumed < P, and out-of-range inputs give an unspecified verdict.

## Structure
- Package `ecc_pkg`:
  - localparam `ECC_W = 256`.
  - The secp256k1 P and B constants.
  - The state enum `pv_state_t`.
  - `MUL_CYCLES = 257`.
- Sub-module `mod_mul_serial`, reusable by later stages:
  - Inputs: start, a, b, modulus.
  - Outputs: done pulse, result.
  - Fixed 257-cycle latency from start to done.
- point_validate holds only the FSM, capture registers, the range comparators and the final add/compare.

## Test plan
All hex values below are the secp256k1 generator coordinates; cycle numbers assume the macro is defined unless stated.
- Generator G (Px=79BE667E…16F81798, Py=483ADA77…FB10D4B8), k=1 → out_valid in cycle 774, on_curve=1, Qx/Qy equal to G, k_o=1.
- (Gx, Gy+1) → on_curve=0 in cycle 774.
- Px=P, Py=Gy → on_curve=0 in cycle 2. With the macro undefined, only the cycle-773 timing is checked.
- (0,0) → on_curve=0 in cycle 774. Second in_valid pulse at cycle 100 → ignored; exactly one out_valid and Qx unchanged.
- rst pulsed at cycle 300 during MUL_XX → all outputs 0 within the same cycle, no out_valid. A following G capture then yields on_curve=1 exactly 774 cycles later.
- Two G points sent back-to-back (second in_valid at cycle 775) → two out_valid pulses at 774 and 1549, both with on_curve=1.
